mux_nto1_seq: RTL and testbench

- Parametrised, registered N:1 multiplexer; the successor to the lab 2:1 combinational mux.
- Selects one of NCH input channels of WIDTH bits each.
- Channel changes are break-before-make: one blanking cycle with out_valid low.
- Two modes: manual (load a new select) and scan (round-robin through channels, staying DWELL cycles on each).
- Used as a reusable source-select stage in lab datapaths.

---
 rtl/mux_nto1_seq.sv | 147 ++++++++++++++
 tb/tb_mux_nto1_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_seq.sv
// mux_nto1_seq: registered N:1 source-select stage.
// Channel changes are break-before-make: the output is blanked for exactly one
// cycle (out_valid low, out zero) before data from the new channel appears.
// Manual mode switches on a sel_load strobe. Scan mode steps round-robin
// through the channels, staying max(dwell,1) valid cycles on each one.
// The FSM state is visible internally as state_q (RUN / BLANK).
module mux_nto1_seq #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = $clog2(NCH),
   parameter int CNTW  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*WIDTH-1:0]  in_data,
   input  logic                  mode,
   input  logic [SELW-1:0]       sel_req,
   input  logic                  sel_load,
   input  logic [CNTW-1:0]       dwell,
   output logic [WIDTH-1:0]      out,
   output logic                  out_valid,
   output logic [SELW-1:0]       sel_cur,
   output logic                  switch_done,
   output logic                  sel_err
);

   typedef enum logic {RUN = 1'b0, BLANK = 1'b1} state_t;

   localparam int              NSLOT = 2 ** SELW;
   localparam logic [SELW:0]   NCH_X = (SELW + 1)'(NCH);
   localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

   state_t            state_q, state_d;
   logic [SELW-1:0]   pending_q, pending_d;
   logic [SELW-1:0]   sel_cur_q, sel_cur_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              switch_done_q, switch_done_d;
   logic              sel_err_q, sel_err_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              mode_q, mode_d;

   logic [WIDTH-1:0]  ch [NSLOT];
   logic [CNTW-1:0]   dwell_eff;
   logic              mode_chg;
   logic              req_bad;
   logic              cnt_hit;
   logic [SELW-1:0]   next_ch;

   // Unpack the channel bus; unused slots (non power-of-two NCH) read as zero.
   always_comb begin
      for (int i = 0; i < NSLOT; i++) begin
         ch[i] = '0;
         if (i < NCH) ch[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Helper terms: effective dwell, mode edge, bad request, dwell compare, next scan channel.
   always_comb begin
      dwell_eff = (dwell == '0) ? CNTW'(1) : dwell;
      mode_chg  = (mode != mode_q);
      req_bad   = ({1'b0, sel_req} >= NCH_X);
      // >= rather than == so that shrinking dwell mid-scan switches on the next edge.
      cnt_hit   = (({1'b0, cnt_q} + (CNTW + 1)'(1)) >= {1'b0, dwell_eff});
      next_ch   = (sel_cur_q == LAST) ? '0 : sel_cur_q + SELW'(1);
   end

   // Next-state and output logic of the RUN/BLANK controller.
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      sel_cur_d     = sel_cur_q;
      out_d         = ch[sel_cur_q];
      out_valid_d   = 1'b1;
      switch_done_d = 1'b0;
      sel_err_d     = 1'b0;
      cnt_d         = cnt_q;
      mode_d        = mode;
      case (state_q)
         RUN: begin
            if (!mode) begin
               if (sel_load) begin
                  if (req_bad) begin
                     sel_err_d = 1'b1;
                  end else if (sel_req != sel_cur_q) begin
                     pending_d   = sel_req;
                     out_d       = '0;
                     out_valid_d = 1'b0;
                     state_d     = BLANK;
                  end
               end
            end else if (!mode_chg) begin
               if (cnt_hit) begin
                  cnt_d       = '0;
                  pending_d   = next_ch;
                  out_d       = '0;
                  out_valid_d = 1'b0;
                  state_d     = BLANK;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
         end
         BLANK: begin
            // The blank always completes, whatever mode or sel_load do now.
            sel_cur_d     = pending_q;
            out_d         = ch[pending_q];
            switch_done_d = 1'b1;
            state_d       = RUN;
         end
         default: state_d = RUN;
      endcase
      if (mode_chg) cnt_d = '0;
   end

   // State registers; reset discards any pending switch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         pending_q     <= '0;
         sel_cur_q     <= '0;
         out_q         <= '0;
         out_valid_q   <= 1'b0;
         switch_done_q <= 1'b0;
         sel_err_q     <= 1'b0;
         cnt_q         <= '0;
         mode_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         sel_cur_q     <= sel_cur_d;
         out_q         <= out_d;
         out_valid_q   <= out_valid_d;
         switch_done_q <= switch_done_d;
         sel_err_q     <= sel_err_d;
         cnt_q         <= cnt_d;
         mode_q        <= mode_d;
      end
   end

   assign out         = out_q;
   assign out_valid   = out_valid_q;
   assign sel_cur     = sel_cur_q;
   assign switch_done = switch_done_q;
   assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Directed testbench for mux_nto1_seq: a 4-channel instance for the main
// behaviour and a 3-channel instance for the out-of-range select case.
module tb_mux_nto1_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
   logic        mode = 1'b0;
   logic [1:0]  sel_req = '0;
   logic        sel_load = 1'b0;
   logic [7:0]  dwell = 8'd3;
   logic [7:0]  out;
   logic        out_valid;
   logic [1:0]  sel_cur;
   logic        switch_done;
   logic        sel_err;

   logic [23:0] in_data3 = {8'h33, 8'h22, 8'h11};
   logic [1:0]  sel_req3 = '0;
   logic        sel_load3 = 1'b0;
   logic [7:0]  out3;
   logic        out_valid3;
   logic [1:0]  sel_cur3;
   logic        switch_done3;
   logic        sel_err3;

   int n_vec = 0;
   int n_err = 0;

   // clock / reset
   always #5 clk = ~clk;

   mux_nto1_seq #(.WIDTH(8), .NCH(4), .CNTW(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .mode(mode),
      .sel_req(sel_req), .sel_load(sel_load), .dwell(dwell),
      .out(out), .out_valid(out_valid), .sel_cur(sel_cur),
      .switch_done(switch_done), .sel_err(sel_err)
   );

   mux_nto1_seq #(.WIDTH(8), .NCH(3), .CNTW(8)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .mode(1'b0),
      .sel_req(sel_req3), .sel_load(sel_load3), .dwell(8'd1),
      .out(out3), .out_valid(out_valid3), .sel_cur(sel_cur3),
      .switch_done(switch_done3), .sel_err(sel_err3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ch_val(input int c);
      return 8'hA0 + 8'(c * 8'h11);
   endfunction

   // check a stream of expected channels; -1 denotes a blank cycle
   task automatic run_seq(input string tag, input int seq[$]);
      int prev = -2;
      foreach (seq[i]) begin
         tick();
         if (seq[i] < 0) begin
            check({tag, "_valid"}, out_valid, 0);
            check({tag, "_out"}, out, 0);
         end else begin
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_out"}, out, ch_val(seq[i]));
            check({tag, "_sel"}, sel_cur, seq[i]);
         end
         check({tag, "_done"}, switch_done, (prev == -1) ? 1 : 0);
         prev = seq[i];
      end
   endtask

   initial begin
      int scan3[$];
      int scan0[$];
      int toggle[$];
      int done_cnt;

      // reset state
      repeat (2) tick();
      check("rst_out", out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_sel", sel_cur, 0);
      rst = 1'b0;
      tick();
      check("first_out", out, 8'hA0);
      check("first_valid", out_valid, 1);
      check("first_sel", sel_cur, 0);

      // manual switch to channel 2
      sel_req = 2'd2; sel_load = 1'b1;
      tick();
      sel_load = 1'b0;
      check("man_blank_valid", out_valid, 0);
      check("man_blank_out", out, 0);
      check("man_blank_sel", sel_cur, 0);
      tick();
      check("man_out", out, 8'hC2);
      check("man_sel", sel_cur, 2);
      check("man_done", switch_done, 1);
      check("man_valid", out_valid, 1);
      tick();
      check("man_done_off", switch_done, 0);
      check("man_hold", out, 8'hC2);

      // reload of the current channel: no blank, no pulse
      sel_req = 2'd2; sel_load = 1'b1;
      tick();
      sel_load = 1'b0;
      check("same_valid", out_valid, 1);
      check("same_out", out, 8'hC2);
      check("same_done", switch_done, 0);
      check("same_err", sel_err, 0);

      // out-of-range select on the 3-channel instance
      sel_req3 = 2'd3; sel_load3 = 1'b1;
      tick();
      sel_load3 = 1'b0;
      check("err_pulse", sel_err3, 1);
      check("err_sel", sel_cur3, 0);
      check("err_valid", out_valid3, 1);
      check("err_out", out3, 8'h11);
      tick();
      check("err_off", sel_err3, 0);
      check("err_nodone", switch_done3, 0);

      // sel_load during BLANK is ignored
      sel_req = 2'd1; sel_load = 1'b1;
      tick();
      sel_req = 2'd3;
      check("ign_blank", out_valid, 0);
      tick();
      sel_load = 1'b0;
      check("ign_sel", sel_cur, 1);
      check("ign_done", switch_done, 1);
      tick();
      check("ign_no_blank", out_valid, 1);
      check("ign_sel_hold", sel_cur, 1);

      // scan, dwell=3, starting from channel 1
      mode = 1'b1; dwell = 8'd3;
      scan3 = '{1, 1, 1, -1, 2, 2, 2, -1, 3, 3, 3, -1, 0, 0, 0, -1, 1};
      done_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (switch_done) done_cnt++;
         if (scan3[i] < 0) begin
            check("scan3_valid", out_valid, 0);
         end else begin
            check("scan3_out", out, ch_val(scan3[i]));
            check("scan3_sel", sel_cur, scan3[i]);
         end
      end
      tick();
      if (switch_done) done_cnt++;
      check("scan3_wrap", sel_cur, 1);
      check("scan3_pulses", done_cnt, 4);

      // dwell=0 behaves as 1: one valid cycle per channel
      dwell = 8'd0;
      scan0 = '{-1, 2, -1, 3, -1, 0};
      run_seq("scan0", scan0);

      // leave scan mode mid-BLANK: switch completes, then channel is held
      tick();
      check("tog_blank", out_valid, 0);
      mode = 1'b0;
      toggle = '{1, 1, 1, 1};
      tick();
      check("tog_out", out, 8'hB1);
      check("tog_sel", sel_cur, 1);
      check("tog_done", switch_done, 1);
      run_seq("tog_hold", toggle);

      // async reset between edges in the middle of a blank
      sel_req = 2'd3; sel_load = 1'b1;
      tick();
      sel_load = 1'b0;
      check("arst_blank", out_valid, 0);
      check("arst_pre_sel", sel_cur, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_sel", sel_cur, 0);
      check("arst_valid", out_valid, 0);
      check("arst_out", out, 0);
      tick();
      rst = 1'b0;
      tick();
      check("arst_rel_sel", sel_cur, 0);
      check("arst_rel_out", out, 8'hA0);
      check("arst_rel_done", switch_done, 0);
      check("arst_rel_valid", out_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
